// File: rtl/uart_pwm_led_ctrl_if.sv
// Register-style link between the LED controller and a simpleuart data port.
// The controller is the master: it strobes reads and requests writes.
interface uart_pwm_led_ctrl_if;
    logic        reg_dat_re;
    logic [31:0] reg_dat_do;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait;

    modport master (
        output reg_dat_re,
        output reg_dat_we,
        output reg_dat_di,
        input  reg_dat_do,
        input  reg_dat_wait
    );

    modport slave (
        input  reg_dat_re,
        input  reg_dat_we,
        input  reg_dat_di,
        output reg_dat_do,
        output reg_dat_wait
    );
endinterface

// File: rtl/uart_pwm_led_ctrl.sv
// UART command parser driving NUM_CH PWM channels; frames are "<ch><hex digits>" or "R",
// answered with 'K' or '?'. Duty updates are double-buffered and applied at period wrap.
module uart_pwm_led_ctrl #(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter bit          INVERT         = 1'b0
) (
    input  logic                hw_clk,
    input  logic                rst,
    uart_pwm_led_ctrl_if.master uart,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                frame_err
);

    localparam int unsigned NDIG  = PWM_BITS / 4;
    localparam int unsigned IDX_W = $clog2(NDIG + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NDIG);
    localparam logic [7:0]          CHR_ACK  = 8'h4B;
    localparam logic [7:0]          CHR_NACK = 8'h3F;

    typedef enum logic [1:0] {StPoll, StConsume, StParse, StTx} state_e;

    state_e              state_q;
    logic [7:0]          byte_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CH_W-1:0]     ch_q;
    logic [PWM_BITS-1:0] acc_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic                re_q;
    logic                we_q;
    logic [7:0]          di_q;
    logic                frame_err_q;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] active_q [NUM_CH];
    logic [NUM_CH-1:0]   pwm_q;
    logic [NUM_CH-1:0]   raw;

    logic                is_hex;
    logic                is_ch;
    logic [3:0]          nib;
    logic [7:0]          ch_off;
    logic [PWM_BITS-1:0] acc_next;

    assign uart.reg_dat_re = re_q;
    assign uart.reg_dat_we = we_q;
    assign uart.reg_dat_di = {24'h0, di_q};
    assign frame_err       = frame_err_q;
    assign pwm_out         = pwm_q;

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
            is_hex = 1'b1;
            nib    = 4'(byte_q - 8'h30);
        end else if (byte_q >= 8'h41 && byte_q <= 8'h46) begin
            is_hex = 1'b1;
            nib    = 4'(byte_q - 8'h37);
        end else if (byte_q >= 8'h61 && byte_q <= 8'h66) begin
            is_hex = 1'b1;
            nib    = 4'(byte_q - 8'h57);
        end
        ch_off   = byte_q - 8'h30;
        is_ch    = (byte_q >= 8'h30) && ({24'h0, ch_off} < NUM_CH);
        acc_next = (acc_q << 4) | PWM_BITS'(nib);
    end

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StPoll;
            byte_q      <= '0;
            idx_q       <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            di_q        <= '0;
            frame_err_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
        end else begin
            re_q        <= 1'b0;
            frame_err_q <= 1'b0;
            // Saturating idle counter, only meaningful inside a frame.
            if (idx_q != '0 && tmo_q != TMO_LAST) tmo_q <= tmo_q + TMO_W'(1);
            unique case (state_q)
                StPoll: begin
                    if (uart.reg_dat_do != 32'hFFFF_FFFF) begin
                        byte_q  <= uart.reg_dat_do[7:0];
                        re_q    <= 1'b1;
                        state_q <= StConsume;
                    end else if (idx_q != '0 && tmo_q == TMO_LAST) begin
                        idx_q <= '0;
                        acc_q <= '0;
                        tmo_q <= '0;
                    end
                end
                StConsume: begin
                    tmo_q   <= '0;
                    state_q <= StParse;
                end
                StParse: begin
                    state_q <= StPoll;
                    if (idx_q == '0) begin
                        if (byte_q == 8'h52) begin
                            for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
                            di_q    <= CHR_ACK;
                            we_q    <= 1'b1;
                            state_q <= StTx;
                        end else if (is_ch) begin
                            ch_q  <= CH_W'(ch_off);
                            idx_q <= IDX_W'(1);
                            acc_q <= '0;
                        end else if (byte_q != 8'h0D && byte_q != 8'h0A) begin
                            di_q        <= CHR_NACK;
                            we_q        <= 1'b1;
                            frame_err_q <= 1'b1;
                            state_q     <= StTx;
                        end
                    end else if (is_hex) begin
                        if (idx_q == IDX_LAST) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (c == int'(ch_q)) shadow_q[c] <= acc_next;
                            end
                            idx_q   <= '0;
                            acc_q   <= '0;
                            di_q    <= CHR_ACK;
                            we_q    <= 1'b1;
                            state_q <= StTx;
                        end else begin
                            acc_q <= acc_next;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_q       <= '0;
                        acc_q       <= '0;
                        di_q        <= CHR_NACK;
                        we_q        <= 1'b1;
                        frame_err_q <= 1'b1;
                        state_q     <= StTx;
                    end
                end
                StTx: begin
                    if (!uart.reg_dat_wait) begin
                        we_q    <= 1'b0;
                        state_q <= StPoll;
                    end
                end
                default: state_q <= StPoll;
            endcase
        end
    end

    always_comb begin
        raw = '0;
        for (int c = 0; c < NUM_CH; c++) raw[c] = (cnt_q < active_q[c]);
    end

    // Period is 2^PWM_BITS-1 so an all-ones duty is a steady high.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= {NUM_CH{INVERT}};
            for (int c = 0; c < NUM_CH; c++) active_q[c] <= '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                for (int c = 0; c < NUM_CH; c++) active_q[c] <= shadow_q[c];
            end else begin
                cnt_q <= cnt_q + PWM_BITS'(1);
            end
            pwm_q <= raw ^ {NUM_CH{INVERT}};
        end
    end

endmodule

// File: tb/tb_uart_pwm_led_ctrl.sv
// Directed plus randomized bench for uart_pwm_led_ctrl against a byte-stream reference model.
// PWM is judged by counting high cycles over one full period.
module tb_uart_pwm_led_ctrl;

    localparam int NCH    = 3;
    localparam int PERIOD = 255;

    logic           hw_clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] pwm_out;
    logic           frame_err;

    uart_pwm_led_ctrl_if bus ();

    uart_pwm_led_ctrl #(
        .NUM_CH         (NCH),
        .PWM_BITS       (8),
        .TIMEOUT_CYCLES (100),
        .INVERT         (1'b0)
    ) dut (
        .hw_clk    (hw_clk),
        .rst       (rst),
        .uart      (bus),
        .pwm_out   (pwm_out),
        .frame_err (frame_err)
    );

    always #5 hw_clk = ~hw_clk;

    // UART-side monitor: counts strobes and captures accepted transmit bytes.
    int         re_cnt = 0, re_double = 0, we_cycles = 0, ferr_cnt = 0, ferr_double = 0;
    int         di_bad = 0;
    logic       re_prev = 1'b0, ferr_prev = 1'b0;
    logic [7:0] tx_q [$];

    always @(posedge hw_clk) begin
        re_prev   <= bus.reg_dat_re;
        ferr_prev <= frame_err;
        if (bus.reg_dat_re) re_cnt <= re_cnt + 1;
        if (bus.reg_dat_re && re_prev) re_double <= re_double + 1;
        if (bus.reg_dat_we) we_cycles <= we_cycles + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (frame_err && ferr_prev) ferr_double <= ferr_double + 1;
        if (bus.reg_dat_we && !bus.reg_dat_wait) begin
            tx_q.push_back(bus.reg_dat_di[7:0]);
            if (bus.reg_dat_di[31:8] != 24'h0) di_bad <= di_bad + 1;
        end
    end

    int passed = 0, failed = 0, total = 0;
    int tx_rd  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame rules applied to the byte stream.
    int         m_idx, m_ch, m_acc;
    int         m_shadow [NCH];
    logic [7:0] exp_q [$];

    function automatic int hex_val(input int b);
        if (b >= 48 && b <= 57) return b - 48;
        if (b >= 65 && b <= 70) return b - 55;
        if (b >= 97 && b <= 102) return b - 87;
        return -1;
    endfunction

    function automatic int hex_chr(input int v, input bit up);
        if (v < 10) return 48 + v;
        return (up ? 55 : 87) + v;
    endfunction

    function automatic void model_reset();
        m_idx = 0;
        m_ch  = 0;
        m_acc = 0;
        for (int c = 0; c < NCH; c++) m_shadow[c] = 0;
        exp_q.delete();
    endfunction

    function automatic void model_timeout();
        m_idx = 0;
        m_acc = 0;
    endfunction

    function automatic void model_byte(input int b);
        int v;
        v = hex_val(b);
        if (m_idx == 0) begin
            if (b == 82) begin
                for (int c = 0; c < NCH; c++) m_shadow[c] = 0;
                exp_q.push_back(8'h4B);
            end else if (b >= 48 && b < 48 + NCH) begin
                m_ch  = b - 48;
                m_idx = 1;
                m_acc = 0;
            end else if (b != 13 && b != 10) begin
                exp_q.push_back(8'h3F);
            end
        end else if (v < 0) begin
            m_idx = 0;
            exp_q.push_back(8'h3F);
        end else begin
            m_acc = m_acc * 16 + v;
            if (m_idx == 2) begin
                m_shadow[m_ch] = m_acc;
                m_idx = 0;
                exp_q.push_back(8'h4B);
            end else begin
                m_idx++;
            end
        end
    endfunction

    // Called just after a negedge; returns just after a negedge with the DUT back in POLL or TX.
    task automatic send(input int b);
        int n;
        n = 0;
        model_byte(b);
        bus.reg_dat_do = {24'h0, 8'(b)};
        do begin
            @(negedge hw_clk);
            n++;
        end while (bus.reg_dat_re !== 1'b1 && n < 60);
        check("re_seen", 32'(n >= 60), 32'd0);
        bus.reg_dat_do = 32'hFFFF_FFFF;
        @(negedge hw_clk);
        check("re_one_cycle", 32'(bus.reg_dat_re), 32'd0);
        repeat (3) @(negedge hw_clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(int'(s[i]));
    endtask

    task automatic check_replies(input string tag);
        int got;
        got = tx_q.size() - tx_rd;
        check({tag, "_nreply"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < got && i < exp_q.size(); i++)
            check({tag, "_reply"}, 32'(tx_q[tx_rd + i]), 32'(exp_q[i]));
        tx_rd = tx_q.size();
        exp_q.delete();
    endtask

    task automatic measure_pwm(input string tag);
        int hi [NCH];
        repeat (2 * PERIOD + 4) @(negedge hw_clk);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        repeat (PERIOD) begin
            @(negedge hw_clk);
            for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
        end
        for (int c = 0; c < NCH; c++) check(tag, 32'(hi[c]), 32'(m_shadow[c]));
    endtask

    initial begin
        int          r0, w0, f0, bad, pwm_hi, kind, ch, v;
        logic [31:0] held;

        rst              = 1'b1;
        bus.reg_dat_do   = 32'hFFFF_FFFF;
        bus.reg_dat_wait = 1'b0;
        model_reset();
        #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_re", 32'(bus.reg_dat_re), 32'd0);
        check("rst_we", 32'(bus.reg_dat_we), 32'd0);
        check("rst_di", bus.reg_dat_di, 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        repeat (2) @(negedge hw_clk);
        rst = 1'b0;

        // Idle after reset
        r0 = re_cnt; w0 = we_cycles; f0 = ferr_cnt; pwm_hi = 0;
        repeat (300) begin
            @(negedge hw_clk);
            if (pwm_out != '0) pwm_hi++;
        end
        check("idle_re", 32'(re_cnt - r0), 32'd0);
        check("idle_we", 32'(we_cycles - w0), 32'd0);
        check("idle_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("idle_pwm", 32'(pwm_hi), 32'd0);

        // Half duty on channel 1
        r0 = re_cnt;
        send_str("180");
        check("t2_re_pulses", 32'(re_cnt - r0), 32'd3);
        check_replies("t2");
        measure_pwm("t2_pwm");

        // Full duty on channel 2, then a broken frame
        send_str("2FF");
        check_replies("t3a");
        f0 = ferr_cnt;
        send_str("0g");
        check_replies("t3b");
        check("t3_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        measure_pwm("t3_pwm");

        // Reply held off by a busy UART
        send_str("04");
        bus.reg_dat_wait = 1'b1;
        send(48);
        check("t4_we_high", 32'(bus.reg_dat_we), 32'd1);
        held = bus.reg_dat_di;
        check("t4_di", held, 32'h4B);
        bad = 0;
        repeat (40) begin
            @(negedge hw_clk);
            if (bus.reg_dat_we !== 1'b1 || bus.reg_dat_di !== held) bad++;
        end
        check("t4_hold_stable", 32'(bad), 32'd0);
        check("t4_none_accepted", 32'(tx_q.size() - tx_rd), 32'd0);
        bus.reg_dat_wait = 1'b0;
        @(negedge hw_clk);
        check("t4_we_drop", 32'(bus.reg_dat_we), 32'd0);
        check_replies("t4");
        measure_pwm("t4_pwm");

        // Partial frame abandoned by timeout
        send(49);
        repeat (150) @(negedge hw_clk);
        model_timeout();
        send_str("40");
        check_replies("t5");
        repeat (150) @(negedge hw_clk);
        model_timeout();
        measure_pwm("t5_pwm");

        // Reset-all command, then asynchronous reset during a pending reply
        send_str("040");
        check_replies("t6a");
        measure_pwm("t6a_pwm");
        send(82);
        check_replies("t6b");
        measure_pwm("t6b_pwm");
        send_str("2FF");
        check_replies("t6c");
        measure_pwm("t6c_pwm");
        bus.reg_dat_wait = 1'b1;
        send_str("100");
        check("t6_we_pending", 32'(bus.reg_dat_we), 32'd1);
        check("t6_pwm_before", 32'(pwm_out), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("t6_async_we", 32'(bus.reg_dat_we), 32'd0);
        check("t6_async_pwm", 32'(pwm_out), 32'd0);
        check("t6_async_ferr", 32'(frame_err), 32'd0);
        model_reset();
        @(negedge hw_clk);
        rst = 1'b0;
        bus.reg_dat_wait = 1'b0;
        repeat (20) @(negedge hw_clk);
        check("t6_reply_dropped", 32'(tx_q.size() - tx_rd), 32'd0);
        tx_rd = tx_q.size();
        measure_pwm("t6_after_rst");

        // Randomized command stream
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, NCH - 1);
            if (kind <= 5) begin
                send(48 + ch);
                send(hex_chr($urandom_range(0, 15), 1'($urandom_range(0, 1))));
                send(hex_chr($urandom_range(0, 15), 1'($urandom_range(0, 1))));
            end else if (kind == 6) begin
                send(48 + ch);
                send(hex_chr($urandom_range(0, 15), 1'($urandom_range(0, 1))));
                send(71 + $urandom_range(0, 19));
            end else if (kind == 7) begin
                v = $urandom_range(0, 3);
                if (v == 0) send(51 + $urandom_range(0, 6));
                else if (v == 1) send(81);
                else if (v == 2) send(13);
                else send(10);
            end else if (kind == 8) begin
                send(82);
            end else begin
                send(48 + ch);
                if ($urandom_range(0, 1) == 1) send(hex_chr($urandom_range(0, 15), 1'b1));
                repeat (150) @(negedge hw_clk);
                model_timeout();
            end
            check_replies("rnd");
            repeat ($urandom_range(0, 4)) @(negedge hw_clk);
        end
        measure_pwm("rnd_pwm");

        check("re_never_double", 32'(re_double), 32'd0);
        check("ferr_never_long", 32'(ferr_double), 32'd0);
        check("di_upper_zero", 32'(di_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
